// File: rtl/sid_pipe_sched_pkg.sv
// Shared types and timing constants for the SID pipeline scheduler.
// Both voice orderings live here; the top picks one via SID_VOICE3_FIRST_EN.
package sid;

   typedef logic [4:0] sched_k_t;

   // Slot s of the per-core voice order occupies bits [2s+1:2s].
   typedef logic [5:0] voice_order_t;

   localparam sched_k_t SCHED_LEN     = 5'd19;
   localparam sched_k_t SCHED_F1_LOAD = 5'd4;
   localparam sched_k_t SCHED_F2_LOAD = 5'd11;
   localparam int       FILTER_STAGES = 7;

   localparam voice_order_t VOICE_ORDER_DEFAULT  = {2'd2, 2'd1, 2'd0};
   localparam voice_order_t VOICE_ORDER_V3_FIRST = {2'd1, 2'd0, 2'd2};

   typedef struct packed {
      logic       busy;
      logic       voice_load;
      logic       voice_core;
      logic [1:0] voice_no;
      logic       result_valid;
      logic       result_core;
      logic [1:0] result_no;
      logic       voice_active;
      logic [1:0] osc3_strobe;
      logic       filter_load;
      logic       filter_core;
      logic [2:0] filter_stage;
      logic [1:0] filter_done;
      logic       overrun;
   } sched_out_t;

   function automatic logic [1:0] voice_at(input voice_order_t ord, input logic [1:0] slot);
      return ord[{slot, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/sid_pipe_sched.sv
// 19-cycle scheduler sharing the voice and filter pipelines between two SID cores.
// SID_VOICE3_FIRST_EN: feed voice3 first in each core so OSC3 readback is earlier.
module sid_pipe_sched
   import sid::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       voice_load,
   output logic       voice_core,
   output logic [1:0] voice_no,
   output logic       result_valid,
   output logic       result_core,
   output logic [1:0] result_no,
   output logic       voice_active,
   output logic [1:0] osc3_strobe,
   output logic       filter_load,
   output logic       filter_core,
   output logic [2:0] filter_stage,
   output logic [1:0] filter_done,
   output logic       overrun
);

`ifdef SID_VOICE3_FIRST_EN
   localparam voice_order_t ORDER = VOICE_ORDER_V3_FIRST;
`else
   localparam voice_order_t ORDER = VOICE_ORDER_DEFAULT;
`endif

   localparam sched_k_t F1_LAST = SCHED_F1_LOAD + sched_k_t'(FILTER_STAGES);
   localparam sched_k_t F2_LAST = SCHED_F2_LOAD + sched_k_t'(FILTER_STAGES);

   sched_k_t   k_q, k_d;
   sched_out_t out_q, out_d;
   logic       start_ok;
   sched_k_t   load_idx, res_idx;

   // Index 0..5 across both cores -> slot 0..2 within a core.
   function automatic logic [1:0] slot_of(input sched_k_t idx);
      return (idx >= 5'd3) ? 2'(idx - 5'd3) : 2'(idx);
   endfunction

   always_comb begin
      k_d      = '0;
      out_d    = '0;
      load_idx = k_d - 5'd1;
      res_idx  = k_d - 5'd2;
      start_ok = (k_q == 5'd0) || (k_q == SCHED_LEN);

      if (start && start_ok) begin
         k_d = 5'd1;
      end else if (k_q != 5'd0 && k_q != SCHED_LEN) begin
         k_d = k_q + 5'd1;
      end

      // Outputs are decoded from the next count so they line up with k once registered.
      load_idx = k_d - 5'd1;
      res_idx  = k_d - 5'd2;

      out_d.overrun = out_q.overrun | (start & ~start_ok);
      out_d.busy    = (k_d != 5'd0);

      if (k_d >= 5'd1 && k_d <= 5'd6) begin
         out_d.voice_load = 1'b1;
         out_d.voice_core = (k_d >= 5'd4);
         out_d.voice_no   = voice_at(ORDER, slot_of(load_idx));
      end

      if (k_d >= 5'd2 && k_d <= 5'd7) begin
         out_d.result_valid = 1'b1;
         out_d.voice_active = 1'b1;
         out_d.result_core  = (k_d >= 5'd5);
         out_d.result_no    = voice_at(ORDER, slot_of(res_idx));
         if (out_d.result_no == 2'd2) begin
            out_d.osc3_strobe = out_d.result_core ? 2'b10 : 2'b01;
         end
      end

      out_d.filter_load = (k_d == SCHED_F1_LOAD) || (k_d == SCHED_F2_LOAD);
      out_d.filter_core = (k_d >= SCHED_F2_LOAD) && (k_d <= F2_LAST);

      if (k_d > SCHED_F1_LOAD && k_d <= F1_LAST) begin
         out_d.filter_stage = 3'(k_d - SCHED_F1_LOAD);
      end else if (k_d > SCHED_F2_LOAD && k_d <= F2_LAST) begin
         out_d.filter_stage = 3'(k_d - SCHED_F2_LOAD);
      end

      out_d.filter_done[0] = (k_d == F1_LAST + 5'd1);
      out_d.filter_done[1] = (k_d == F2_LAST + 5'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q   <= '0;
         out_q <= '0;
      end else begin
         k_q   <= k_d;
         out_q <= out_d;
      end
   end

   assign busy         = out_q.busy;
   assign voice_load   = out_q.voice_load;
   assign voice_core   = out_q.voice_core;
   assign voice_no     = out_q.voice_no;
   assign result_valid = out_q.result_valid;
   assign result_core  = out_q.result_core;
   assign result_no    = out_q.result_no;
   assign voice_active = out_q.voice_active;
   assign osc3_strobe  = out_q.osc3_strobe;
   assign filter_load  = out_q.filter_load;
   assign filter_core  = out_q.filter_core;
   assign filter_stage = out_q.filter_stage;
   assign filter_done  = out_q.filter_done;
   assign overrun      = out_q.overrun;

endmodule

// File: tb/tb_sid_pipe_sched.sv
// Scoreboard bench for sid_pipe_sched: stimulus queues per-cycle expected outputs, a monitor checks them.
module tb_sid_pipe_sched;
   import sid::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, voice_load, voice_core, result_valid, result_core, voice_active;
   logic       filter_load, filter_core, overrun;
   logic [1:0] voice_no, result_no, osc3_strobe, filter_done;
   logic [2:0] filter_stage;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         k;
      sched_out_t v;
   } exp_t;

   exp_t       sb_q[$];
   sched_out_t act;

   always #5 clk = ~clk;

   sid_pipe_sched dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .voice_load(voice_load), .voice_core(voice_core), .voice_no(voice_no),
      .result_valid(result_valid), .result_core(result_core), .result_no(result_no),
      .voice_active(voice_active), .osc3_strobe(osc3_strobe),
      .filter_load(filter_load), .filter_core(filter_core), .filter_stage(filter_stage),
      .filter_done(filter_done), .overrun(overrun)
   );

   assign act = '{busy, voice_load, voice_core, voice_no, result_valid, result_core, result_no,
                  voice_active, osc3_strobe, filter_load, filter_core, filter_stage, filter_done, overrun};

   // Hand-tabulated outputs for cycle k of a sequence (k = 0 is idle).
   function automatic sched_out_t expect_at(input int k, input bit ovr);
      sched_out_t e;
      e = '0;
      e.busy         = (k >= 1 && k <= 19);
      e.voice_load   = (k >= 1 && k <= 6);
      e.voice_core   = (k >= 4 && k <= 6);
      e.result_valid = (k >= 2 && k <= 7);
      e.result_core  = (k >= 5 && k <= 7);
      e.voice_active = e.result_valid;
`ifdef SID_VOICE3_FIRST_EN
      case (k)
         1: e.voice_no = 2'd2;  2: e.voice_no = 2'd0;  3: e.voice_no = 2'd1;
         4: e.voice_no = 2'd2;  5: e.voice_no = 2'd0;  6: e.voice_no = 2'd1;
         default: e.voice_no = 2'd0;
      endcase
      case (k)
         2: e.result_no = 2'd2;  3: e.result_no = 2'd0;  4: e.result_no = 2'd1;
         5: e.result_no = 2'd2;  6: e.result_no = 2'd0;  7: e.result_no = 2'd1;
         default: e.result_no = 2'd0;
      endcase
      if (k == 2) e.osc3_strobe = 2'b01;
      if (k == 5) e.osc3_strobe = 2'b10;
`else
      case (k)
         1: e.voice_no = 2'd0;  2: e.voice_no = 2'd1;  3: e.voice_no = 2'd2;
         4: e.voice_no = 2'd0;  5: e.voice_no = 2'd1;  6: e.voice_no = 2'd2;
         default: e.voice_no = 2'd0;
      endcase
      case (k)
         2: e.result_no = 2'd0;  3: e.result_no = 2'd1;  4: e.result_no = 2'd2;
         5: e.result_no = 2'd0;  6: e.result_no = 2'd1;  7: e.result_no = 2'd2;
         default: e.result_no = 2'd0;
      endcase
      if (k == 4) e.osc3_strobe = 2'b01;
      if (k == 7) e.osc3_strobe = 2'b10;
`endif
      e.filter_load = (k == 4) || (k == 11);
      e.filter_core = (k >= 11 && k <= 18);
      case (k)
         5, 12:  e.filter_stage = 3'd1;
         6, 13:  e.filter_stage = 3'd2;
         7, 14:  e.filter_stage = 3'd3;
         8, 15:  e.filter_stage = 3'd4;
         9, 16:  e.filter_stage = 3'd5;
         10, 17: e.filter_stage = 3'd6;
         11, 18: e.filter_stage = 3'd7;
         default: e.filter_stage = 3'd0;
      endcase
      if (k == 12) e.filter_done = 2'b01;
      if (k == 19) e.filter_done = 2'b10;
      e.overrun = ovr;
      return e;
   endfunction

   // Called at a negedge; raises start and walks to the negedge inside k = 19.
   // extra_k: issue a stray start at that k. abort_k: pulse rst_n during that k.
   task automatic run_seq(input int extra_k, input bit ovr_in, input int abort_k, input bit last);
      exp_t e;
      start = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         e.k = k;
         e.v = expect_at(k, ovr_in || (extra_k != 0 && k > extra_k));
         sb_q.push_back(e);
      end
      if (last) begin
         e.k = 0;
         e.v = expect_at(0, ovr_in || (extra_k != 0));
         sb_q.push_back(e);
      end
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == abort_k) begin
            start = 1'b0;
            rst_n = 1'b0;
            #1;
            checks++;
            if (act !== sched_out_t'('0)) begin
               errors++;
               $display("FAIL async_reset k=%0d got=%h want=%h", k, act, sched_out_t'('0));
            end
            sb_q.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         start = (k == extra_k);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (act !== e.v) begin
               errors++;
               $display("FAIL sched_k%0d got=%h want=%h", e.k, act, e.v);
            end
         end
      end
   end

   initial begin : stimulus
      #1;
      checks++;
      if (act !== sched_out_t'('0)) begin
         errors++;
         $display("FAIL reset_state got=%h want=%h", act, sched_out_t'('0));
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single sequence followed by idle.
      run_seq(0, 1'b0, 0, 1'b1);
      repeat (3) @(negedge clk);

      // Back-to-back restarts at k = 19.
      run_seq(0, 1'b0, 0, 1'b0);
      run_seq(0, 1'b0, 0, 1'b0);
      run_seq(0, 1'b0, 0, 1'b1);
      repeat (2) @(negedge clk);

      // Stray start at k = 10, then overrun must remain sticky.
      run_seq(10, 1'b0, 0, 1'b1);
      repeat (2) @(negedge clk);
      run_seq(0, 1'b1, 0, 1'b1);
      repeat (2) @(negedge clk);

      // Reset at k = 8 clears everything; the next start behaves like the first.
      run_seq(0, 1'b1, 8, 1'b0);
      run_seq(0, 1'b0, 0, 1'b1);
      repeat (3) @(negedge clk);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
